// File: rtl/float_mul_issue.sv
// -----------------------------------------------------------------------------
// float_mul_issue
//
// Issue stage in front of a pipelined floating-point multiplier. Operand pairs
// arrive on a single AXI-Stream slave, are buffered in a small FIFO and are
// presented to the multiplier's two operand channels (a and b) in lockstep.
// A pair leaves the FIFO only when both operand channels accept it in the same
// cycle. The number of pairs issued to the multiplier but not yet retired is
// tracked and capped at MAX_INFLIGHT. The cap keeps the multiplier's result
// path from being overrun.
//
// Parameters
//   SIZE          operand width in bits (64 = IEEE-754 binary64)
//   DEPTH         operand-pair buffer entries, power of two, >= 2
//   MAX_INFLIGHT  maximum issued-but-unretired pairs, >= 1
//
// Ports
//   aclk             in   sole clock, rising edge
//   aresetn          in   synchronous active-low reset
//   s_axis_tdata     in   operand pair: a = [SIZE-1:0], b = [2*SIZE-1:SIZE]
//   s_axis_tvalid    in   operand pair valid
//   s_axis_tready    out  buffer has room (low while aresetn is low)
//   m_axis_a_tdata   out  operand a to the multiplier
//   m_axis_a_tvalid  out  operand a valid (always equal to m_axis_b_tvalid)
//   m_axis_a_tready  in   multiplier ready on channel a
//   m_axis_b_tdata   out  operand b to the multiplier
//   m_axis_b_tvalid  out  operand b valid
//   m_axis_b_tready  in   multiplier ready on channel b
//   result_fire      in   one-cycle pulse per multiplier result handshake
//   inflight         out  issued, unretired pair count
//   idle             out  buffer empty and nothing in flight
//   issued_count     out  (stats build only) issue events, 32-bit wrapping
//   retired_count    out  (stats build only) honoured retires, 32-bit wrapping
//
// Build option
//   FLOAT_MUL_ISSUE_STATS_EN  when defined, adds issued_count / retired_count.
//                             When undefined those ports and counters are absent
//                             and the rest of the behaviour is unchanged.
// -----------------------------------------------------------------------------

module float_mul_issue #(
    parameter int SIZE         = 64,
    parameter int DEPTH        = 4,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                              aclk,
    input  logic                              aresetn,

    input  logic [2*SIZE-1:0]                 s_axis_tdata,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,

    output logic [SIZE-1:0]                   m_axis_a_tdata,
    output logic                              m_axis_a_tvalid,
    input  logic                              m_axis_a_tready,
    output logic [SIZE-1:0]                   m_axis_b_tdata,
    output logic                              m_axis_b_tvalid,
    input  logic                              m_axis_b_tready,

    input  logic                              result_fire,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
`ifdef FLOAT_MUL_ISSUE_STATS_EN
    output logic [31:0]                       issued_count,
    output logic [31:0]                       retired_count,
`endif
    output logic                              idle
);

    // -------------------------------------------------------------------------
    // Derived widths and typed limits
    // -------------------------------------------------------------------------
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;   // pointer width
    localparam int CW = $clog2(DEPTH + 1);                 // occupancy width
    localparam int IW = $clog2(MAX_INFLIGHT + 1);          // inflight width

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [IW-1:0] MAX_C   = IW'(MAX_INFLIGHT);

    // Elaboration-time parameter sanity checks.
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("float_mul_issue: DEPTH must be a power of two >= 2");
    end
    if (MAX_INFLIGHT < 1) begin : g_bad_max
        $error("float_mul_issue: MAX_INFLIGHT must be >= 1");
    end

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [2*SIZE-1:0] mem_q [DEPTH];   // whole pairs, a in the low half

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [IW-1:0] inflight_q, inflight_d;

    // -------------------------------------------------------------------------
    // Handshake decode
    // -------------------------------------------------------------------------
    logic fifo_nonempty;
    logic below_limit;
    logic issue_valid;
    logic push;
    logic pop;
    logic retire;

    assign fifo_nonempty = (count_q != '0);
    assign below_limit   = (inflight_q < MAX_C);

    // Room is judged on registered occupancy only, so a same-cycle pop does
    // not open the input; this keeps s_axis_tready free of any path from the
    // multiplier's ready inputs. It is forced low while reset is applied.
    assign s_axis_tready = aresetn && (count_q < DEPTH_C);

    // Both operand channels share one valid; the in-flight cap gates it so a
    // full multiplier pipeline stalls issue without touching the buffer.
    assign issue_valid   = aresetn && fifo_nonempty && below_limit;

    assign push = s_axis_tvalid && s_axis_tready;

    // A pair is issued only when both channels take it in the same cycle; a
    // single ready on its own leaves the head, and therefore tdata, untouched.
    assign pop  = issue_valid && m_axis_a_tready && m_axis_b_tready;

    // A retire with nothing in flight is a stale pulse (for example from a
    // pair discarded by reset) and is dropped. A same-cycle issue makes a
    // retire legal even from zero, so the count nets out unchanged.
    assign retire = result_fire && ((inflight_q != '0) || pop);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output is defaulted first, so no path
        // through this block leaves a variable unassigned and no latch is
        // inferred.
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = inflight_q;

        // DEPTH is a power of two, so pointer increments wrap naturally.
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;     // idle, or push and pop together
        endcase

        unique case ({pop, retire})
            2'b10:   inflight_d = inflight_q + 1'b1;
            2'b01:   inflight_d = inflight_q - 1'b1;
            default: inflight_d = inflight_q;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers (synchronous active-low reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (!aresetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

    // -------------------------------------------------------------------------
    // Pair storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset. Occupancy and pointers define
    // which entries are meaningful, and leaving the array unreset lets it map
    // onto plain RAM or register files.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef FLOAT_MUL_ISSUE_STATS_EN
    logic [31:0] issued_cnt_q;
    logic [31:0] retired_cnt_q;

    // 32-bit counters wrap on overflow; only honoured retires are counted.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            issued_cnt_q  <= '0;
            retired_cnt_q <= '0;
        end else begin
            if (pop) begin
                issued_cnt_q <= issued_cnt_q + 32'd1;
            end
            if (retire) begin
                retired_cnt_q <= retired_cnt_q + 32'd1;
            end
        end
    end

    assign issued_count  = issued_cnt_q;
    assign retired_count = retired_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    // The head entry is read straight from storage. It only changes on a pop,
    // so tdata is stable for as long as valid waits for both readies. While
    // valid is low the value is don't-care.
    logic [2*SIZE-1:0] head_pair;
    assign head_pair = mem_q[rd_ptr_q];

    assign m_axis_a_tdata  = head_pair[SIZE-1:0];
    assign m_axis_b_tdata  = head_pair[2*SIZE-1:SIZE];
    assign m_axis_a_tvalid = issue_valid;
    assign m_axis_b_tvalid = issue_valid;

    assign inflight = inflight_q;
    assign idle     = (count_q == '0) && (inflight_q == '0);

endmodule
